// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT/BTB predictor: Fetch lookup, Decode resolve/update; optional stats under BP_STATS_EN.
// Latency: lookup and resolution are combinational; table update lands on the next rising clk.
// Backpressure: StallD suppresses the table update, the stats and MispredictD.
module branch_predict_unit #(
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 6,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] PCF,
    output logic              PredTakenF,
    output logic [DATA_W-1:0] PredTargetF,
    input  logic              BranchD,
    input  logic              BneD,
    input  logic [DATA_W-1:0] PCD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic [DATA_W-1:0] SignImm,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [1:0]        ForwardAD,
    input  logic [1:0]        ForwardBD,
    input  logic              PredTakenD,
    input  logic              StallD,
    output logic [DATA_W-1:0] PCBranchD,
    output logic              TakenD,
    output logic              MispredictD,
    output logic [DATA_W-1:0] RedirectPCD,
    output logic [31:0]       BranchCount,
    output logic [31:0]       MispredCount
);
    localparam int DEPTH = 2**IDX_W;
    localparam int TAG_W = DATA_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};

    logic              valid_q [DEPTH];
    logic [CTR_W-1:0]  ctr_q   [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [DATA_W-1:0] tgt_q   [DEPTH];

    logic [IDX_W-1:0]  idx_fet, idx_dec;
    logic [TAG_W-1:0]  tag_fet, tag_dec;
    logic              hit_fet, hit_dec;
    logic [DATA_W-1:0] op_a, op_b;
    logic              eq, upd_en, alias_clr;
    logic              st_we, tt_we;
    logic              ent_valid_d;
    logic [CTR_W-1:0]  ent_ctr_d;
    logic              unused_pc_lsb;

    assign unused_pc_lsb = ^{PCF[1:0], PCD[1:0]};

    // Fetch lookup reads only registered state, so a same-cycle update is seen next cycle.
    assign idx_fet     = PCF[IDX_W+1:2];
    assign tag_fet     = PCF[DATA_W-1:IDX_W+2];
    assign hit_fet     = valid_q[idx_fet] && (tag_q[idx_fet] == tag_fet);
    assign PredTakenF  = hit_fet && ctr_q[idx_fet][CTR_W-1];
    assign PredTargetF = PredTakenF ? tgt_q[idx_fet] : PCF + DATA_W'(4);

    always_comb begin
        case (ForwardAD)
            2'b01:   op_a = ALUOutM;
            2'b10:   op_a = ResultW;
            default: op_a = RD1;
        endcase
        case (ForwardBD)
            2'b01:   op_b = ALUOutM;
            2'b10:   op_b = ResultW;
            default: op_b = RD2;
        endcase
    end

    assign eq          = (op_a == op_b);
    assign TakenD      = BranchD && (BneD ? !eq : eq);
    assign PCBranchD   = PCPlus4D + (SignImm << 2);
    assign RedirectPCD = TakenD ? PCBranchD : PCPlus4D;
    assign MispredictD = !StallD && (TakenD != PredTakenD);

    assign idx_dec   = PCD[IDX_W+1:2];
    assign tag_dec   = PCD[DATA_W-1:IDX_W+2];
    assign hit_dec   = valid_q[idx_dec] && (tag_q[idx_dec] == tag_dec);
    assign upd_en    = BranchD && !StallD;
    // A predicted-taken non-branch means the entry aliased onto another instruction.
    assign alias_clr = !BranchD && !StallD && PredTakenD && hit_dec;

    always_comb begin
        tt_we       = upd_en && (hit_dec || TakenD);
        st_we       = tt_we || alias_clr;
        ent_valid_d = 1'b1;
        ent_ctr_d   = CTR_WT;
        if (alias_clr) begin
            ent_valid_d = 1'b0;
            ent_ctr_d   = CTR_RST;
        end else if (hit_dec) begin
            if (TakenD)
                ent_ctr_d = (ctr_q[idx_dec] == CTR_MAX) ? CTR_MAX : ctr_q[idx_dec] + CTR_W'(1);
            else
                ent_ctr_d = (ctr_q[idx_dec] == '0) ? '0 : ctr_q[idx_dec] - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RST;
            end
        end else if (st_we) begin
            valid_q[idx_dec] <= ent_valid_d;
            ctr_q[idx_dec]   <= ent_ctr_d;
        end
    end

    // Tag/target are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (tt_we) begin
            tag_q[idx_dec] <= tag_dec;
            tgt_q[idx_dec] <= PCBranchD;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q, mp_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (upd_en)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (MispredictD)
                mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    assign BranchCount  = br_cnt_q;
    assign MispredCount = mp_cnt_q;
`else
    assign BranchCount  = '0;
    assign MispredCount = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: expectations queued at drive time, popped at the sample point.
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF, PredTargetF, PCD, PCPlus4D, SignImm, RD1, RD2, ALUOutM, ResultW;
    logic [31:0] PCBranchD, RedirectPCD, BranchCount, MispredCount;
    logic        PredTakenF, BranchD, BneD, PredTakenD, StallD, TakenD, MispredictD;
    logic [1:0]  ForwardAD, ForwardBD;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .BranchD(BranchD), .BneD(BneD), .PCD(PCD), .PCPlus4D(PCPlus4D), .SignImm(SignImm),
        .RD1(RD1), .RD2(RD2), .ALUOutM(ALUOutM), .ResultW(ResultW),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .PredTakenD(PredTakenD), .StallD(StallD),
        .PCBranchD(PCBranchD), .TakenD(TakenD), .MispredictD(MispredictD),
        .RedirectPCD(RedirectPCD), .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_bc = 0;
    int   exp_mc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] probe(input string t);
        if (t == "PredTakenF")   return {31'b0, PredTakenF};
        if (t == "PredTargetF")  return PredTargetF;
        if (t == "TakenD")       return {31'b0, TakenD};
        if (t == "MispredictD")  return {31'b0, MispredictD};
        if (t == "RedirectPCD")  return RedirectPCD;
        if (t == "PCBranchD")    return PCBranchD;
        if (t == "BranchCount")  return BranchCount;
        if (t == "MispredCount") return MispredCount;
        return 'x;
    endfunction

    task automatic expect_val(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_f(input logic pt, input logic [31:0] tgt);
        expect_val("PredTakenF", {31'b0, pt});
        expect_val("PredTargetF", tgt);
    endtask

    task automatic exp_res(input logic tk, input logic mp, input logic [31:0] redir);
        expect_val("TakenD", {31'b0, tk});
        expect_val("MispredictD", {31'b0, mp});
        expect_val("RedirectPCD", redir);
    endtask

    task automatic exp_stats();
`ifdef BP_STATS_EN
        expect_val("BranchCount", exp_bc);
        expect_val("MispredCount", exp_mc);
`else
        expect_val("BranchCount", 32'd0);
        expect_val("MispredCount", 32'd0);
`endif
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, probe(e.tag), e.exp);
        end
    endtask

    task automatic idle();
        BranchD = 0; BneD = 0; PredTakenD = 0; StallD = 0;
        ForwardAD = 2'b00; ForwardBD = 2'b00;
    endtask

    task automatic dec(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic bne, input logic pt, input logic st);
        BranchD = 1; BneD = bne; PCD = pc; PCPlus4D = pc + 32'd4; SignImm = imm;
        RD1 = a; RD2 = b; PredTakenD = pt; StallD = st;
        ForwardAD = 2'b00; ForwardBD = 2'b00;
    endtask

    // Compare at the falling edge, then let the rising edge commit and account for its side effects.
    task automatic step(input bit elig, input bit mp);
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        if (elig) exp_bc++;
        if (mp)   exp_mc++;
    endtask

    initial begin
        rst_n = 0;
        idle();
        PCF = 32'h0040_0010; PCD = 0; PCPlus4D = 0; SignImm = 0;
        RD1 = 0; RD2 = 0; ALUOutM = 0; ResultW = 0;
        #12 rst_n = 1;
        @(posedge clk);
        #1;

        // Reset state
        exp_f(0, 32'h0040_0014);
        expect_val("MispredictD", 0);
        exp_stats();
        step(0, 0);

        // First BEQ taken: miss, mispredict, allocate; lookup same cycle still sees old state
        dec(32'h0040_0010, 32'd4, 5, 5, 0, 0, 0);
        exp_res(1, 1, 32'h0040_0024);
        expect_val("PCBranchD", 32'h0040_0024);
        exp_f(0, 32'h0040_0014);
        step(1, 1);
        idle();
        exp_f(1, 32'h0040_0024);
        step(0, 0);

        // Three more taken (counter saturates), then two not-taken
        for (int i = 0; i < 3; i++) begin
            dec(32'h0040_0010, 32'd4, 5, 5, 0, 1, 0);
            exp_res(1, 0, 32'h0040_0024);
            exp_f(1, 32'h0040_0024);
            step(1, 0);
        end
        dec(32'h0040_0010, 32'd4, 5, 6, 0, 1, 0);
        exp_res(0, 1, 32'h0040_0014);
        step(1, 1);
        idle();
        exp_f(1, 32'h0040_0024);
        step(0, 0);
        dec(32'h0040_0010, 32'd4, 5, 6, 0, 1, 0);
        exp_res(0, 1, 32'h0040_0014);
        step(1, 1);
        idle();
        exp_f(0, 32'h0040_0014);
        step(0, 0);

        // BNE with forwarding: ALUOutM on A equals RD2 -> not taken, no allocation
        dec(32'h0040_0100, 32'hFFFF_FFFE, 1, 7, 1, 0, 0);
        ForwardAD = 2'b01; ALUOutM = 7;
        exp_res(0, 0, 32'h0040_0104);
        step(1, 0);
        idle();
        PCF = 32'h0040_0100;
        exp_f(0, 32'h0040_0104);
        step(0, 0);
        dec(32'h0040_0100, 32'hFFFF_FFFE, 1, 7, 1, 0, 0);
        ForwardAD = 2'b01; ForwardBD = 2'b10; ALUOutM = 7; ResultW = 8;
        exp_res(1, 1, 32'h0040_00FC);
        expect_val("PCBranchD", 32'h0040_00FC);
        step(1, 1);
        idle();
        exp_f(1, 32'h0040_00FC);
        step(0, 0);
        // Select 11 must pick the register file, not a forward path
        dec(32'h0040_0100, 32'hFFFF_FFFE, 3, 4, 1, 1, 0);
        ForwardAD = 2'b11; ForwardBD = 2'b11; ALUOutM = 9; ResultW = 9;
        exp_res(1, 0, 32'h0040_00FC);
        step(1, 0);

        // Same index, different tag: no hit
        idle();
        PCF = 32'h0040_0200;
        exp_f(0, 32'h0040_0204);
        step(0, 0);

        // Stall suppresses mispredict and update; release applies both
        dec(32'h0040_0208, 32'd8, 2, 2, 0, 0, 1);
        exp_res(1, 0, 32'h0040_022C);
        step(0, 0);
        idle();
        PCF = 32'h0040_0208;
        exp_f(0, 32'h0040_020C);
        step(0, 0);
        dec(32'h0040_0208, 32'd8, 2, 2, 0, 0, 0);
        exp_res(1, 1, 32'h0040_022C);
        step(1, 1);
        idle();
        exp_f(1, 32'h0040_022C);
        step(0, 0);

        // Predicted-taken non-branch: redirect to fall-through and invalidate the entry
        idle();
        PredTakenD = 1; PCD = 32'h0040_0208; PCPlus4D = 32'h0040_020C;
        exp_res(0, 1, 32'h0040_020C);
        step(0, 1);
        idle();
        exp_f(0, 32'h0040_020C);
        exp_stats();
        step(0, 0);

        // Asynchronous reset mid-cycle clears table and stats without a clock edge
        PCF = 32'h0040_0100;
        exp_f(1, 32'h0040_00FC);
        @(negedge clk);
        drain();
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        exp_f(0, 32'h0040_0104);
        exp_bc = 0;
        exp_mc = 0;
        exp_stats();
        expect_val("MispredictD", 0);
        drain();
        #10 rst_n = 1;

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
